ascon_out_buf: RTL and testbench
================================

# ascon_out_buf

Output-side buffer for the Ascon core, sitting between the core's `bdo`/`auth` outputs and the host or system bus. It accepts ciphertext, plaintext, tag and hash words under the core's valid/ready handshake, stores them in a small FIFO with their type and end-of-type flags, and re-presents them to the host with independent backpressure. It also captures the tag-verification result into a sticky register, so the core never stalls on a slow host.

## Interface
Parameters:
- `CCW`, 32: data word width; must match the core's `bdo` width.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `bdo` in CCW: data word from the core.
- `bdo_valid` in 1: core output word valid.
- `bdo_ready` out 1: buffer accepts `bdo`.
- `bdo_type` in 4: `D_*` type code of `bdo`.
- `bdo_eot` in 1: last word of the current type.
- `auth` in 1: tag verification result; 1 = tag match.
- `auth_valid` in 1: `auth` valid.
- `auth_ready` out 1: buffer accepts `auth`.
- `out_data` out CCW: head-of-FIFO word.
- `out_type` out 4: head-of-FIFO type.
- `out_eot` out 1: head-of-FIFO end-of-type flag.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: host takes the head word.
- `auth_out` out 1: captured verification result.
- `auth_out_valid` out 1: `auth_out` holds an unread result.
- `auth_clr` in 1: host acknowledges `auth_out`.
- `seg_len` out 16: word count of the last completed segment (`ASCON_OUT_CNT_EN` only).
- `seg_done` out 1: one-cycle pulse when a segment completes (`ASCON_OUT_CNT_EN` only).

## Operation
- FIFO entry is {`eot`, `type[3:0]`, `data[CCW-1:0]`}.
- The FIFO uses `$clog2(DEPTH)+1`-bit read/write pointers; pointers wrap modulo 2·DEPTH.
  - Full when the MSBs differ and the low bits are equal.
  - Empty when the pointers are equal.
- Push when `bdo_valid & bdo_ready` and `bdo_type != D_NULL`.
  - A `bdo_valid` word with type `D_NULL` is handshaken (`bdo_ready` still applies) and discarded.
- `bdo_ready = !full`, driven from registered state only, with no combinational path from `out_ready`.
  - When full, a simultaneous pop does not enable a push in that cycle.
- Pop when `out_valid & out_ready`.
  - `out_data`, `out_type` and `out_eot` are read from the read pointer and are stable while `out_valid & !out_ready`.
- Push and pop in the same cycle when neither full nor empty: occupancy is unchanged.
- Auth register:
  - `auth_ready = !auth_out_valid`.
  - On `auth_valid & auth_ready`: `auth_out <= auth`, `auth_out_valid <= 1`.
  - `auth_clr` clears `auth_out_valid`; `auth_out` keeps its value.
  - Capture and `auth_clr` in the same cycle cannot collide, because capture requires `auth_out_valid == 0`. `auth_clr` while not valid has no effect.
- Auth and FIFO paths are independent; there is no ordering between the auth result and buffered words.

## Timing
- Reset values: `bdo_ready`=1, `auth_ready`=1, `out_valid`=0, `out_data`=0, `out_type`=0, `out_eot`=0, `auth_out`=0, `auth_out_valid`=0, `seg_len`=0, `seg_done`=0. Pointers and counter are 0.
- Reset asserted mid-operation discards all FIFO contents and any pending auth result immediately (asynchronous).
- Latency: a word accepted at edge n gives `out_valid`=1 after edge n (visible in cycle n+1). There is no same-cycle pass-through.
- Throughput: one word per cycle in steady state when `out_ready` is held at 1.
- Full: `bdo_ready` goes 0 in the cycle after the DEPTH-th push. It returns to 1 in the cycle after the first pop.
- Auth: `auth_out_valid` rises in the cycle after capture. `auth_ready` returns to 1 in the cycle after `auth_clr`.

## Configuration
- `ASCON_OUT_CNT_EN` defined:
  - A 16-bit counter increments on each pop and saturates at 0xFFFF.
  - On a pop with `out_eot`=1: `seg_len <= count+1` (saturating), `seg_done` pulses for one cycle, and the counter clears to 0.
- Not defined: the counter logic is absent, and `seg_len`/`seg_done` are tied to 0.

## Test plan
- Reset, then push `D_PTCT` words 0x11111111 and 0x22222222 (eot on the second) with `out_ready`=1 → identical words appear in order, one cycle after acceptance, with `out_eot`=1 on 0x22222222. With `ASCON_OUT_CNT_EN`: `seg_len`=2 and `seg_done` pulses once.
- Hold `out_ready`=0 and push 9 words with DEPTH=8 → `bdo_ready`=0 after the 8th push and the 9th word is held at the core. One pop re-raises `bdo_ready` in the next cycle; the host then reads all 9 words in order.
- Push words with interleaved `D_NULL` types → the `D_NULL` words are consumed and never appear on `out_*`.
- `auth_valid`=1 with `auth`=1 → `auth_out`=1, `auth_out_valid`=1, `auth_ready`=0. A second `auth_valid` with `auth`=0 is stalled until `auth_clr`; it is then captured and `auth_out`=0.
- Push 4 words, then assert `rst` for one cycle mid-stream → `out_valid`=0 and all outputs are at their reset values. A new word pushed after reset is the first word output.
- Push a 4-word `D_TAG` segment ending in eot, then a 2-word `D_HASH` segment, with random `out_ready` → data is intact. With `ASCON_OUT_CNT_EN`: `seg_len`=4 then 2.

Source files
------------

// File: rtl/ascon_out_buf.sv
// Output buffer between the Ascon core's bdo/auth outputs and the host: a word FIFO plus a sticky auth register.
// Optional segment word counter (seg_len/seg_done) is enabled by defining ASCON_OUT_CNT_EN.
module ascon_out_buf #(
   parameter int CCW   = 32,
   parameter int DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [CCW-1:0] bdo,
   input  logic           bdo_valid,
   output logic           bdo_ready,
   input  logic [3:0]     bdo_type,
   input  logic           bdo_eot,
   input  logic           auth,
   input  logic           auth_valid,
   output logic           auth_ready,
   output logic [CCW-1:0] out_data,
   output logic [3:0]     out_type,
   output logic           out_eot,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           auth_out,
   output logic           auth_out_valid,
   input  logic           auth_clr,
   output logic [15:0]    seg_len,
   output logic           seg_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = CCW + 5;
   localparam logic [3:0] D_NULL = 4'h0;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [EW-1:0] head;
   logic          full;
   logic          empty;
   logic          hs_in;
   logic          push;
   logic          pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   assign bdo_ready = !full;
   assign out_valid = !empty;
   assign hs_in     = bdo_valid && bdo_ready;
   assign push      = hs_in && (bdo_type != D_NULL);
   assign pop       = out_valid && out_ready;

   // NOTE: the storage array has no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {bdo_eot, bdo_type, bdo};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Masking with empty keeps outputs at zero after reset, when the array is undefined.
   assign head     = mem[rd_ptr[AW-1:0]];
   assign out_data = empty ? '0   : head[CCW-1:0];
   assign out_type = empty ? 4'h0 : head[CCW+3:CCW];
   assign out_eot  = !empty && head[CCW+4];

   assign auth_ready = !auth_out_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         auth_out       <= 1'b0;
         auth_out_valid <= 1'b0;
      end else if (auth_valid && auth_ready) begin
         auth_out       <= auth;
         auth_out_valid <= 1'b1;
      end else if (auth_clr) begin
         auth_out_valid <= 1'b0;
      end
   end

`ifdef ASCON_OUT_CNT_EN
   logic [15:0] cnt;
   logic [15:0] cnt_inc;

   assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         seg_len  <= '0;
         seg_done <= 1'b0;
      end else begin
         seg_done <= 1'b0;
         if (pop) begin
            if (out_eot) begin
               seg_len  <= cnt_inc;
               seg_done <= 1'b1;
               cnt      <= '0;
            end else begin
               cnt <= cnt_inc;
            end
         end
      end
   end
`else
   assign seg_len  = '0;
   assign seg_done = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_out_buf.sv
// Directed bench for ascon_out_buf: drives and samples on the falling edge, checks against hand-computed values.
module tb_ascon_out_buf;

   localparam logic [3:0] D_NULL = 4'h0;
   localparam logic [3:0] D_PTCT = 4'h5;
   localparam logic [3:0] D_TAG  = 4'h8;
   localparam logic [3:0] D_HASH = 4'h9;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bdo;
   logic        bdo_valid;
   logic        bdo_ready;
   logic [3:0]  bdo_type;
   logic        bdo_eot;
   logic        auth;
   logic        auth_valid;
   logic        auth_ready;
   logic [31:0] out_data;
   logic [3:0]  out_type;
   logic        out_eot;
   logic        out_valid;
   logic        out_ready;
   logic        auth_out;
   logic        auth_out_valid;
   logic        auth_clr;
   logic [15:0] seg_len;
   logic        seg_done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ascon_out_buf #(.CCW(32), .DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
      .bdo_type(bdo_type), .bdo_eot(bdo_eot),
      .auth(auth), .auth_valid(auth_valid), .auth_ready(auth_ready),
      .out_data(out_data), .out_type(out_type), .out_eot(out_eot),
      .out_valid(out_valid), .out_ready(out_ready),
      .auth_out(auth_out), .auth_out_valid(auth_out_valid), .auth_clr(auth_clr),
      .seg_len(seg_len), .seg_done(seg_done)
   );

   task automatic check_reset_values(input string tag);
      n_cmp++; if (bdo_ready !== 1'b1) begin n_bad++; $display("FAIL %s bdo_ready got %b want 1", tag, bdo_ready); end
      n_cmp++; if (auth_ready !== 1'b1) begin n_bad++; $display("FAIL %s auth_ready got %b want 1", tag, auth_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s out_valid got %b want 0", tag, out_valid); end
      n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL %s out_data got %h want 0", tag, out_data); end
      n_cmp++; if (out_type !== 4'h0) begin n_bad++; $display("FAIL %s out_type got %h want 0", tag, out_type); end
      n_cmp++; if (out_eot !== 1'b0) begin n_bad++; $display("FAIL %s out_eot got %b want 0", tag, out_eot); end
      n_cmp++; if (auth_out !== 1'b0) begin n_bad++; $display("FAIL %s auth_out got %b want 0", tag, auth_out); end
      n_cmp++; if (auth_out_valid !== 1'b0) begin n_bad++; $display("FAIL %s auth_out_valid got %b want 0", tag, auth_out_valid); end
      n_cmp++; if (seg_len !== 16'h0) begin n_bad++; $display("FAIL %s seg_len got %h want 0", tag, seg_len); end
      n_cmp++; if (seg_done !== 1'b0) begin n_bad++; $display("FAIL %s seg_done got %b want 0", tag, seg_done); end
   endtask

   task automatic test_reset;
      rst = 1'b1; bdo = '0; bdo_valid = 0; bdo_type = D_NULL; bdo_eot = 0;
      auth = 0; auth_valid = 0; auth_clr = 0; out_ready = 0;
      #12;
      check_reset_values("reset_hold");
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check_reset_values("reset_release");
   endtask

   task automatic test_basic;
      bdo = 32'h11111111; bdo_type = D_PTCT; bdo_eot = 0; bdo_valid = 1; out_ready = 1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_no_passthru out_valid got %b want 0", out_valid); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h11111111 || out_eot !== 1'b0 || out_type !== D_PTCT)
         begin n_bad++; $display("FAIL basic_w0 got v=%b d=%h t=%h e=%b want 1/11111111/5/0", out_valid, out_data, out_type, out_eot); end
      bdo = 32'h22222222; bdo_eot = 1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h22222222 || out_eot !== 1'b1)
         begin n_bad++; $display("FAIL basic_w1 got v=%b d=%h e=%b want 1/22222222/1", out_valid, out_data, out_eot); end
      bdo_valid = 0; bdo_eot = 0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain out_valid got %b want 0", out_valid); end
`ifdef ASCON_OUT_CNT_EN
      n_cmp++; if (seg_done !== 1'b1 || seg_len !== 16'd2)
         begin n_bad++; $display("FAIL basic_seg got done=%b len=%0d want 1/2", seg_done, seg_len); end
      @(negedge clk);
      n_cmp++; if (seg_done !== 1'b0) begin n_bad++; $display("FAIL basic_seg_pulse seg_done got %b want 0", seg_done); end
`else
      n_cmp++; if (seg_done !== 1'b0 || seg_len !== 16'd0)
         begin n_bad++; $display("FAIL basic_seg_off got done=%b len=%0d want 0/0", seg_done, seg_len); end
`endif
   endtask

   task automatic test_full;
      out_ready = 0; bdo_type = D_PTCT; bdo_eot = 0;
      for (int i = 0; i < 9; i++) begin
         n_cmp++; if (bdo_ready !== (i < 8)) begin n_bad++; $display("FAIL full_ready_%0d got %b want %b", i, bdo_ready, (i < 8)); end
         bdo = 32'hA0 + i; bdo_valid = 1;
         @(negedge clk);
      end
      // word 8 is held at the core while full
      n_cmp++; if (bdo_ready !== 1'b0 || out_data !== 32'hA0)
         begin n_bad++; $display("FAIL full_hold got rdy=%b head=%h want 0/a0", bdo_ready, out_data); end
      out_ready = 1;
      @(negedge clk);
      n_cmp++; if (bdo_ready !== 1'b1 || out_data !== 32'hA1)
         begin n_bad++; $display("FAIL full_pop got rdy=%b head=%h want 1/a1", bdo_ready, out_data); end
      out_ready = 0;
      @(negedge clk);
      bdo_valid = 0;
      n_cmp++; if (bdo_ready !== 1'b0) begin n_bad++; $display("FAIL full_refill bdo_ready got %b want 0", bdo_ready); end
      out_ready = 1;
      for (int k = 1; k < 9; k++) begin
         n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hA0 + k)
            begin n_bad++; $display("FAIL full_read_%0d got v=%b d=%h want 1/%h", k, out_valid, out_data, 32'hA0 + k); end
         @(negedge clk);
      end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_null;
      logic [31:0] d [5] = '{32'h5, 32'h6, 32'h7, 32'h8, 32'h9};
      logic [3:0]  t [5] = '{D_PTCT, D_NULL, D_PTCT, D_NULL, D_TAG};
      logic [31:0] exp_d [3] = '{32'h5, 32'h7, 32'h9};
      logic [31:0] got [$];
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) got.push_back(out_data);
         if (i < 5) begin
            n_cmp++; if (bdo_ready !== 1'b1) begin n_bad++; $display("FAIL null_ready_%0d got %b want 1", i, bdo_ready); end
            bdo = d[i]; bdo_type = t[i]; bdo_eot = (i == 4); bdo_valid = 1;
         end else begin
            bdo_valid = 0; bdo_eot = 0;
         end
         @(negedge clk);
      end
      n_cmp++; if (got.size() !== 3) begin n_bad++; $display("FAIL null_count got %0d want 3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_d[i]) begin n_bad++; $display("FAIL null_word_%0d got %h want %h", i, got[i], exp_d[i]); end
      end
   endtask

   task automatic test_auth;
      auth = 1; auth_valid = 1;
      @(negedge clk);
      n_cmp++; if (auth_out !== 1'b1 || auth_out_valid !== 1'b1 || auth_ready !== 1'b0)
         begin n_bad++; $display("FAIL auth_cap1 got o=%b v=%b r=%b want 1/1/0", auth_out, auth_out_valid, auth_ready); end
      auth = 0;
      @(negedge clk);
      n_cmp++; if (auth_out !== 1'b1 || auth_out_valid !== 1'b1)
         begin n_bad++; $display("FAIL auth_stall got o=%b v=%b want 1/1", auth_out, auth_out_valid); end
      auth_clr = 1;
      @(negedge clk);
      auth_clr = 0;
      n_cmp++; if (auth_out !== 1'b1 || auth_out_valid !== 1'b0 || auth_ready !== 1'b1)
         begin n_bad++; $display("FAIL auth_clr got o=%b v=%b r=%b want 1/0/1", auth_out, auth_out_valid, auth_ready); end
      @(negedge clk);
      auth_valid = 0;
      n_cmp++; if (auth_out !== 1'b0 || auth_out_valid !== 1'b1)
         begin n_bad++; $display("FAIL auth_cap0 got o=%b v=%b want 0/1", auth_out, auth_out_valid); end
      auth_clr = 1;
      @(negedge clk);
      @(negedge clk);
      auth_clr = 0;
      n_cmp++; if (auth_out !== 1'b0 || auth_out_valid !== 1'b0)
         begin n_bad++; $display("FAIL auth_idle_clr got o=%b v=%b want 0/0", auth_out, auth_out_valid); end
   endtask

   task automatic test_reset_mid;
      out_ready = 0; bdo_type = D_PTCT; bdo_eot = 0;
      auth = 1; auth_valid = 1;
      for (int i = 0; i < 4; i++) begin
         bdo = 32'hC0 + i; bdo_valid = 1;
         @(negedge clk);
         auth_valid = 0;
      end
      bdo_valid = 0;
      n_cmp++; if (out_valid !== 1'b1 || auth_out_valid !== 1'b1)
         begin n_bad++; $display("FAIL rstmid_pre got v=%b av=%b want 1/1", out_valid, auth_out_valid); end
      rst = 1;
      #1;
      check_reset_values("rstmid_async");
      @(negedge clk);
      rst = 0;
      out_ready = 1; bdo = 32'hBEEF; bdo_valid = 1;
      @(negedge clk);
      bdo_valid = 0;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hBEEF)
         begin n_bad++; $display("FAIL rstmid_first got v=%b d=%h want 1/0000beef", out_valid, out_data); end
      @(negedge clk);
   endtask

   task automatic test_segments;
      logic [31:0] sd [6] = '{32'h7A61, 32'h7A62, 32'h7A63, 32'h7A64, 32'h4801, 32'h4802};
      logic [3:0]  st [6] = '{D_TAG, D_TAG, D_TAG, D_TAG, D_HASH, D_HASH};
      logic        se [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [15:0] segs [$];
      int sent = 0;
      int got  = 0;
      for (int c = 0; c < 300 && got < 6; c++) begin
         if (seg_done) segs.push_back(seg_len);
         if (sent < 6) begin
            bdo = sd[sent]; bdo_type = st[sent]; bdo_eot = se[sent]; bdo_valid = 1;
         end else begin
            bdo_valid = 0;
         end
         out_ready = 1'($urandom_range(0, 1));
         if (bdo_valid && bdo_ready) sent++;
         if (out_valid && out_ready) begin
            n_cmp++; if (out_data !== sd[got] || out_type !== st[got] || out_eot !== se[got])
               begin n_bad++; $display("FAIL seg_word_%0d got %h/%h/%b want %h/%h/%b", got, out_data, out_type, out_eot, sd[got], st[got], se[got]); end
            got++;
         end
         @(negedge clk);
      end
      bdo_valid = 0; bdo_eot = 0; out_ready = 0;
      if (seg_done) segs.push_back(seg_len);
      n_cmp++; if (got !== 6) begin n_bad++; $display("FAIL seg_timeout received %0d want 6", got); end
`ifdef ASCON_OUT_CNT_EN
      n_cmp++; if (segs.size() !== 2) begin n_bad++; $display("FAIL seg_pulses got %0d want 2", segs.size()); end
      else begin
         n_cmp++; if (segs[0] !== 16'd4 || segs[1] !== 16'd2)
            begin n_bad++; $display("FAIL seg_lens got %0d,%0d want 4,2", segs[0], segs[1]); end
      end
`else
      n_cmp++; if (segs.size() !== 0 || seg_len !== 16'd0)
         begin n_bad++; $display("FAIL seg_off got pulses=%0d len=%0d want 0/0", segs.size(), seg_len); end
`endif
   endtask

   initial begin
      test_reset;
      test_basic;
      test_full;
      test_null;
      test_auth;
      test_reset_mid;
      test_segments;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
